// File: rtl/spi_mem_sequencer_if.sv
// spi_mem_sequencer_if
// Bundles the sequencer's control-side signals so the sequencer and its
// neighbours can be connected through a single port.
//   Driven toward the sequencer (master side):
//     cs         conditioned chip select, 1 = deasserted
//     sclk_rise  one-clk pulse on each SCLK rising edge
//     sclk_fall  one-clk pulse on each SCLK falling edge
//     rw_bit     shift-register parallel out[0], 1 = read, 0 = write
//     lcl_req    local memory request, held until granted
//     lcl_we     local write flag, valid with lcl_req
//   Driven by the sequencer (slave side):
//     addr_le    address latch enable
//     sr_we      shift-register parallel load enable
//     miso_buff  MISO tri-state enable
//     mem_we     data-memory write enable (SPI commit or local write)
//     mem_sel    memory mux select, 0 = SPI latch, 1 = local port
//     lcl_gnt    one-cycle grant to the local port
//     busy       high whenever a transaction is in progress
interface spi_mem_sequencer_if;
  logic cs;
  logic sclk_rise;
  logic sclk_fall;
  logic rw_bit;
  logic lcl_req;
  logic lcl_we;
  logic addr_le;
  logic sr_we;
  logic miso_buff;
  logic mem_we;
  logic mem_sel;
  logic lcl_gnt;
  logic busy;

  modport master (
    output cs, sclk_rise, sclk_fall, rw_bit, lcl_req, lcl_we,
    input  addr_le, sr_we, miso_buff, mem_we, mem_sel, lcl_gnt, busy
  );

  modport slave (
    input  cs, sclk_rise, sclk_fall, rw_bit, lcl_req, lcl_we,
    output addr_le, sr_we, miso_buff, mem_we, mem_sel, lcl_gnt, busy
  );
endinterface

// File: rtl/spi_mem_sequencer.sv
// spi_mem_sequencer
// Sequences one header-plus-data SPI transaction for the SPI-slave memory
// datapath: counts SCLK edges, pulses the address latch, loads the shift
// register from memory on reads, enables the MISO buffer and commits writes.
// It also shares the data memory with a local single-cycle port; the SPI
// memory cycles (RD_MEM, WR_COMMIT) always win.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    spi_mem_sequencer_if.slave (see the interface for signal list)
// Every output is a flop whose D input is decoded from the next state, so
// an output is high in the same cycle as the state it belongs to.
module spi_mem_sequencer #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  spi_mem_sequencer_if.slave bus
);

  localparam int HDR_BITS = ADDR_BITS + 1;
  localparam int MAX_BITS = (HDR_BITS > DATA_BITS) ? HDR_BITS : DATA_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [3:0] {
    IDLE, HDR, DECODE, RD_MEM, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             is_read, is_read_nxt;
  logic             gnt_nxt;
  logic             addr_le_nxt, sr_we_nxt, miso_nxt, mem_we_nxt, busy_nxt;
  logic             addr_le_q, sr_we_q, miso_q, mem_we_q, mem_sel_q, lcl_gnt_q, busy_q;

  // Next-state and next-output decode. The counter is zeroed on every
  // transition so each shift phase starts counting from bit 0. A deasserted
  // chip select overrides everything and returns to IDLE, which also keeps
  // an aborted write from ever reaching WR_COMMIT.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    is_read_nxt = is_read;

    case (state)
      IDLE: begin
        bit_cnt_nxt = '0;
        is_read_nxt = 1'b0;
        if (!bus.cs) state_nxt = HDR;
      end
      HDR: begin
        if (bus.sclk_rise) begin
          if (bit_cnt == HDR_LAST) begin
            state_nxt   = DECODE;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_ONE;
          end
        end
      end
      DECODE: begin
        is_read_nxt = bus.rw_bit;
        bit_cnt_nxt = '0;
        state_nxt   = bus.rw_bit ? RD_MEM : WR_SHIFT;
      end
      RD_MEM:  state_nxt = RD_LOAD;
      RD_LOAD: begin
        state_nxt   = RD_SHIFT;
        bit_cnt_nxt = '0;
      end
      RD_SHIFT: begin
        if (bus.sclk_fall) begin
          if (bit_cnt == DATA_LAST) begin
            state_nxt   = DONE;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_ONE;
          end
        end
      end
      WR_SHIFT: begin
        if (bus.sclk_rise) begin
          if (bit_cnt == DATA_LAST) begin
            state_nxt   = WR_COMMIT;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_ONE;
          end
        end
      end
      WR_COMMIT: state_nxt = DONE;
      DONE:      state_nxt = DONE;
      default:   state_nxt = IDLE;
    endcase

    if (bus.cs) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      is_read_nxt = 1'b0;
    end

    // The local port is kept off the memory whenever the SPI path owns it
    // next cycle, and a fresh grant never follows a grant directly.
    gnt_nxt     = bus.lcl_req && !lcl_gnt_q &&
                  (state_nxt != RD_MEM) && (state_nxt != WR_COMMIT);
    addr_le_nxt = (state_nxt == DECODE);
    sr_we_nxt   = (state_nxt == RD_LOAD);
    miso_nxt    = (state_nxt == RD_SHIFT) || ((state_nxt == DONE) && is_read_nxt);
    mem_we_nxt  = (state_nxt == WR_COMMIT) || (gnt_nxt && bus.lcl_we);
    busy_nxt    = (state_nxt != IDLE);
  end

  // State, counter and registered outputs; reset clears everything at once
  // so an interrupted write can never commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
      addr_le_q <= 1'b0;
      sr_we_q   <= 1'b0;
      miso_q    <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_sel_q <= 1'b0;
      lcl_gnt_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      is_read   <= is_read_nxt;
      addr_le_q <= addr_le_nxt;
      sr_we_q   <= sr_we_nxt;
      miso_q    <= miso_nxt;
      mem_we_q  <= mem_we_nxt;
      mem_sel_q <= gnt_nxt;
      lcl_gnt_q <= gnt_nxt;
      busy_q    <= busy_nxt;
    end
  end

  assign bus.addr_le   = addr_le_q;
  assign bus.sr_we     = sr_we_q;
  assign bus.miso_buff = miso_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.lcl_gnt   = lcl_gnt_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// tb_spi_mem_sequencer
// Drives SPI transactions and local requests cycle by cycle. Each stimulus
// cycle pushes the output vector expected after the next clock edge onto a
// queue; a monitor on the falling edge pops and compares it.
// Output vector order: {addr_le, sr_we, miso_buff, mem_we, mem_sel, lcl_gnt, busy}
module tb_spi_mem_sequencer;

  localparam int ADDR_BITS = 7;
  localparam int DATA_BITS = 8;
  localparam int HDR_BITS  = ADDR_BITS + 1;

  localparam logic [6:0] O_ADDR  = 7'b1000000;
  localparam logic [6:0] O_SRWE  = 7'b0100000;
  localparam logic [6:0] O_MISO  = 7'b0010000;
  localparam logic [6:0] O_MEMWE = 7'b0001000;
  localparam logic [6:0] O_SEL   = 7'b0000100;
  localparam logic [6:0] O_GNT   = 7'b0000010;
  localparam logic [6:0] O_BUSY  = 7'b0000001;

  // Stimulus vector order: {cs, sclk_rise, sclk_fall, rw_bit, lcl_req, lcl_we}
  localparam logic [5:0] I_CS   = 6'b100000;
  localparam logic [5:0] I_RISE = 6'b010000;
  localparam logic [5:0] I_FALL = 6'b001000;
  localparam logic [5:0] I_RW   = 6'b000100;
  localparam logic [5:0] I_REQ  = 6'b000010;
  localparam logic [5:0] I_WE   = 6'b000001;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [6:0] expQ[$];
  string      tagQ[$];
  logic [6:0] obs;

  spi_mem_sequencer_if bus();

  spi_mem_sequencer #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  assign obs = {bus.addr_le, bus.sr_we, bus.miso_buff, bus.mem_we,
                bus.mem_sel, bus.lcl_gnt, bus.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, observed, expected);
    end
  endtask

  // Compare the oldest expectation against what the DUT produced after the
  // preceding rising edge.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      logic [6:0] e;
      string      t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput(t, obs, e);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge
  // that samples them. Returns just after the following falling edge.
  task automatic applyStimulus(input logic [5:0] stim, input logic [6:0] exp, input string tag);
    {bus.cs, bus.sclk_rise, bus.sclk_fall, bus.rw_bit, bus.lcl_req, bus.lcl_we} = stim;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(I_CS, 7'b0, "idle");
  endtask

  // Write transaction. abortAt < DATA_BITS raises cs after that many data
  // rises (together with a further rise that must be ignored). collide
  // raises a local request in the cycle that enters WR_COMMIT.
  task automatic writeTxn(input int abortAt, input logic collide);
    logic       aborted;
    logic       last;
    logic [5:0] req;
    aborted = 1'b0;
    applyStimulus(6'b0, O_BUSY, "wr_start");
    for (int i = 0; i < HDR_BITS; i++) begin
      applyStimulus(I_RISE, (i == HDR_BITS - 1) ? (O_ADDR | O_BUSY) : O_BUSY, "wr_hdr_rise");
      applyStimulus(I_FALL, O_BUSY, "wr_hdr_fall");
    end
    for (int i = 0; i < DATA_BITS && !aborted; i++) begin
      if (i == abortAt) begin
        applyStimulus(I_CS | I_RISE, 7'b0, "wr_abort");
        aborted = 1'b1;
      end else begin
        last = (i == DATA_BITS - 1);
        req  = (last && collide) ? I_REQ : 6'b0;
        applyStimulus(I_RISE | req, last ? (O_MEMWE | O_BUSY) : O_BUSY, "wr_data_rise");
        applyStimulus(I_FALL | req, (last && collide) ? (O_BUSY | O_SEL | O_GNT) : O_BUSY,
                      "wr_data_fall");
      end
    end
    if (aborted) begin
      applyStimulus(I_CS, 7'b0, "wr_abort_idle");
    end else begin
      applyStimulus(I_RISE, O_BUSY, "wr_done_rise");
      applyStimulus(I_FALL, O_BUSY, "wr_done_fall");
      applyStimulus(I_CS, 7'b0, "wr_end");
    end
  endtask

  // Read transaction. resetAt < DATA_BITS fires the asynchronous reset after
  // that many data rises. collide raises a local write request in the
  // DECODE cycle.
  task automatic readTxn(input int resetAt, input logic collide);
    logic       stopped;
    logic [5:0] req;
    stopped = 1'b0;
    req = collide ? (I_REQ | I_WE) : 6'b0;
    applyStimulus(I_RW, O_BUSY, "rd_start");
    for (int i = 0; i < HDR_BITS; i++) begin
      applyStimulus(I_RISE | I_RW, (i == HDR_BITS - 1) ? (O_ADDR | O_BUSY) : O_BUSY, "rd_hdr_rise");
      if (i < HDR_BITS - 1) applyStimulus(I_FALL | I_RW, O_BUSY, "rd_hdr_fall");
    end
    applyStimulus(I_FALL | I_RW | req, O_BUSY, "rd_decode");
    applyStimulus(I_RW | req, O_SRWE | O_BUSY | (collide ? (O_SEL | O_MEMWE | O_GNT) : 7'b0),
                  "rd_load");
    applyStimulus(I_RW, O_MISO | O_BUSY, "rd_shift_entry");
    for (int i = 0; i < DATA_BITS && !stopped; i++) begin
      applyStimulus(I_RISE | I_RW, O_MISO | O_BUSY, "rd_data_rise");
      if (i == resetAt) begin
        reset = 1'b1;
        #1;
        checkOutput("rd_async_reset", obs, 7'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        stopped = 1'b1;
      end else begin
        applyStimulus(I_FALL | I_RW, O_MISO | O_BUSY, "rd_data_fall");
      end
    end
    if (stopped) begin
      applyStimulus(6'b0, O_BUSY, "rd_post_reset_start");
      applyStimulus(I_CS, 7'b0, "rd_post_reset_end");
    end else begin
      applyStimulus(I_FALL | I_RW, O_MISO | O_BUSY, "rd_done_fall");
      applyStimulus(I_CS, 7'b0, "rd_end");
    end
  endtask

  // Local port alone with cs high: grants alternate, mem_we follows lcl_we.
  task automatic localIdleAccess();
    applyStimulus(I_CS | I_REQ, O_SEL | O_GNT, "lcl_gnt1");
    applyStimulus(I_CS | I_REQ, 7'b0, "lcl_gap1");
    applyStimulus(I_CS | I_REQ | I_WE, O_SEL | O_GNT | O_MEMWE, "lcl_gnt2_we");
    applyStimulus(I_CS | I_REQ | I_WE, 7'b0, "lcl_gap2");
    applyStimulus(I_CS, 7'b0, "lcl_release");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    {bus.cs, bus.sclk_rise, bus.sclk_fall, bus.rw_bit, bus.lcl_req, bus.lcl_we} = I_CS;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_state", obs, 7'b0);
    reset = 1'b0;
    idleCycles(2);

    writeTxn(DATA_BITS, 1'b0);
    readTxn(DATA_BITS, 1'b0);
    writeTxn(5, 1'b0);
    writeTxn(DATA_BITS, 1'b1);
    readTxn(DATA_BITS, 1'b1);
    localIdleAccess();
    readTxn(3, 1'b0);
    writeTxn(DATA_BITS, 1'b0);
    idleCycles(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_sequencer.md
# spi_mem_sequencer

Transaction sequencer for the SPI-slave memory datapath: counts SCLK edges, sequences the address latch, shift-register parallel load, MISO buffer and data-memory write enable for one header-plus-data SPI transaction. Also arbitrates the data memory between the SPI path and a local single-cycle access port. The SPI path always has priority. Sits between the input conditioners and the shift register, address latch and data memory.

## Interface
Parameters:
- ADDR_BITS, 7, address bits in header; header = ADDR_BITS + 1 bits (LSB is the R/W flag)
- DATA_BITS, 8, data bits per transaction

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  conditioned chip select; 1 = deasserted
- sclk_rise  in  1  one-clk pulse on SCLK rising edge
- sclk_fall  in  1  one-clk pulse on SCLK falling edge
- rw_bit  in  1  shift-register parallel out[0]; 1 = read, 0 = write
- lcl_req  in  1  local memory access request; held until granted
- lcl_we  in  1  local write flag, valid with lcl_req
- addr_le  out  1  address latch enable
- sr_we  out  1  shift-register parallel load enable
- miso_buff  out  1  MISO tri-state enable
- mem_we  out  1  data-memory write enable
- mem_sel  out  1  memory address/data mux: 0 = SPI latch, 1 = local port
- lcl_gnt  out  1  one-cycle grant to the local port
- busy  out  1  1 whenever the state is not IDLE

## Operation
- All outputs registered. Reset value of every output is 0; state resets to IDLE and bit_cnt to 0.
- bit_cnt width is clog2(max(ADDR_BITS+1, DATA_BITS)+1). It clears on entry to each shift phase.
- States and transitions:
  - IDLE: if cs=0, go to HDR.
  - HDR: count sclk_rise. When the (ADDR_BITS+1)th rise is seen, go to DECODE.
  - DECODE: addr_le=1. If rw_bit=1, go to RD_MEM; otherwise go to WR_SHIFT.
  - RD_MEM: mem_sel=0, memory read cycle. Go to RD_LOAD.
  - RD_LOAD: sr_we=1. Go to RD_SHIFT.
  - RD_SHIFT: miso_buff=1. Count sclk_fall. After DATA_BITS falls, go to DONE.
  - WR_SHIFT: count sclk_rise. After DATA_BITS rises, go to WR_COMMIT.
  - WR_COMMIT: mem_we=1, mem_sel=0. Go to DONE.
  - DONE: miso_buff stays 1 if the transaction was a read. No further SCLK counting. Stay in DONE until cs=1.
- cs=1 in any state:
  - Next edge: state goes to IDLE, bit_cnt goes to 0, and addr_le, sr_we, miso_buff and SPI mem_we drop to 0.
  - An abort before WR_COMMIT never asserts mem_we.
- sclk_rise and sclk_fall pulses are ignored in IDLE, DECODE, RD_MEM, RD_LOAD, WR_COMMIT and DONE.
- Arbitration:
  - At each edge, lcl_gnt <= lcl_req & ~lcl_gnt & (next state not RD_MEM and not WR_COMMIT).
  - While lcl_gnt=1: mem_sel=1 and mem_we = the lcl_we value captured with the grant.
  - The SPI memory cycle and the local grant are never high together.
  - The local port gets at most one grant every 2 cycles; the requester drops lcl_req after lcl_gnt.

## Timing
- Header: the last header sclk_rise sampled at edge E sets state=DECODE. addr_le is high for the single cycle following E.
- Read path:
  - RD_MEM at E+1, sr_we high for the cycle after E+2, miso_buff from E+3.
  - Memory read latency is one clk.
  - The master must leave at least 4 clk between the last header SCLK rise and the first data SCLK fall.
- Write path:
  - The last data sclk_rise at edge W sets WR_COMMIT.
  - mem_we is high for exactly one cycle, after W, and the SPI latch address is still valid then.
- A local request is granted at most 1 clk after it is asserted, except when it collides with RD_MEM or WR_COMMIT; then it is granted 1 clk later.
- Asynchronous reset mid-transaction clears everything immediately, with no commit.

## Test plan
- Write: cs=0, header 0x2A<<1|0, data 0x5C -> addr_le one pulse after the 8th rise, mem_we exactly one pulse after the 16th rise, miso_buff never asserted, busy=0 one clk after cs=1.
- Read: header 0x15<<1|1 -> addr_le, then sr_we 2 clk later; miso_buff from the following clk through DONE until cs=1; mem_we never asserted.
- Abort: cs=1 after 5 data rises of a write -> IDLE next edge, no mem_we; next transaction counts from bit 0 correctly.
- Arbitration collision: lcl_req=1, lcl_we=1 asserted in the cycle the state enters DECODE of a read -> lcl_gnt withheld during RD_MEM, granted one clk later with mem_sel=1 and mem_we=1 for one cycle.
- Idle local access: lcl_req held 4 clk with cs=1 -> lcl_gnt pulses on alternate cycles, mem_sel mirrors lcl_gnt, busy stays 0.
- Reset: assert reset mid RD_SHIFT -> all outputs 0 without waiting for a clk edge; state IDLE after release.
